// File: rtl/flood_pkg.sv
// Shared sizes and FSM state encoding for the Flood-It game engine.
package flood_pkg;
    localparam int unsigned MAX_SIZE  = 26;
    localparam int unsigned MAX_CELLS = MAX_SIZE * MAX_SIZE;
    localparam int unsigned IDX_W     = 10;
    localparam int unsigned ROW_W     = 5;
    localparam int unsigned COLOR_W   = 3;
    localparam int unsigned K_W       = 4;

    typedef enum logic [1:0] {
        IDLE,
        SWEEP,
        SWEEP_END,
        ACK_WAIT
    } state_t;
endpackage

// File: rtl/flood_scan_ctr.sv
// Raster row/col/index counter over an N x N board; saturates on the last cell.
module flood_scan_ctr
    import flood_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_step,
    input  logic [ROW_W-1:0] i_size,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_last,
    output logic             o_col_first,
    output logic             o_col_last,
    output logic             o_row_first,
    output logic             o_row_last
);
    logic [ROW_W-1:0] r_row;
    logic [ROW_W-1:0] r_col;
    logic [IDX_W-1:0] r_idx;
    logic [ROW_W-1:0] w_edge;

    assign w_edge = i_size - ROW_W'(1);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_row <= '0;
            r_col <= '0;
            r_idx <= '0;
        end else if (i_start) begin
            r_row <= '0;
            r_col <= '0;
            r_idx <= '0;
        end else if (i_step && !o_last) begin
            r_idx <= r_idx + IDX_W'(1);
            if (o_col_last) begin
                r_col <= '0;
                r_row <= r_row + ROW_W'(1);
            end else begin
                r_col <= r_col + ROW_W'(1);
            end
        end
    end

    assign o_idx       = r_idx;
    assign o_col_first = (r_col == '0);
    assign o_col_last  = (r_col == w_edge);
    assign o_row_first = (r_row == '0);
    assign o_row_last  = (r_row == w_edge);
    assign o_last      = o_col_last && o_row_last;
endmodule

// File: rtl/flood_engine.sv
// Flood-It game engine: board storage, begin/colour-select handshakes, raster flood sweeps.
// Optional flood counter and win flag are built when WIN_DETECT_EN is defined.
module flood_engine
    import flood_pkg::*;
#(
    parameter int unsigned MAX_SIZE = 26,
    parameter int unsigned COLOR_W  = 3
) (
    input  logic               MASTER_CLOCK,
    input  logic               RESET,
    input  logic [4:0]         final_SIZE,
    input  logic [3:0]         final_COLOR_NUM,
    input  logic               LOAD_WE,
    input  logic [9:0]         LOAD_ADDR,
    input  logic [COLOR_W-1:0] LOAD_COLOR,
    input  logic               BEGIN_GAME,
    output logic               ACK_BEGIN_GAME,
    input  logic               COLOR_SEL_SIG,
    input  logic [COLOR_W-1:0] COLOR_SELECTED,
    output logic               CURRENTLY_CHANGING_COLOR,
    output logic               INITIALIZED,
    input  logic [9:0]         RD_ADDR,
    output logic [COLOR_W-1:0] RD_COLOR,
    output logic [9:0]         FLOOD_COUNT,
    output logic               WON
);
    localparam int unsigned CELLS = MAX_SIZE * MAX_SIZE;

    state_t                         r_state;
    logic [ROW_W-1:0]               r_size;
    logic [K_W-1:0]                 r_knum;
    logic [IDX_W-1:0]               r_nn;
    logic [CELLS-1:0][COLOR_W-1:0]  r_color;
    logic [CELLS-1:0]               r_mask;
    logic [COLOR_W-1:0]             r_target;
    logic                           r_changed;
    logic                           r_begin_mode;
    logic                           r_skip;
    logic                           r_ack;
    logic                           r_busy;
    logic                           r_init;
    logic [COLOR_W-1:0]             r_rd_color;

    logic [IDX_W-1:0] w_idx;
    logic             w_last;
    logic             w_col_first;
    logic             w_col_last;
    logic             w_row_first;
    logic             w_row_last;
    logic             w_nbr;
    logic             w_add;
    logic             w_begin_acc;

    flood_scan_ctr u_scan (
        .i_clk       (MASTER_CLOCK),
        .i_rst       (RESET),
        .i_start     (r_state != SWEEP),
        .i_step      (r_state == SWEEP),
        .i_size      (r_size),
        .o_idx       (w_idx),
        .o_last      (w_last),
        .o_col_first (w_col_first),
        .o_col_last  (w_col_last),
        .o_row_first (w_row_first),
        .o_row_last  (w_row_last)
    );

    // Any flooded 4-neighbour of the current sweep cell, gated at board edges.
    assign w_nbr = (!w_col_first && r_mask[w_idx - IDX_W'(1)])
                || (!w_row_first && r_mask[w_idx - IDX_W'(r_size)])
                || (!w_col_last  && r_mask[w_idx + IDX_W'(1)])
                || (!w_row_last  && r_mask[w_idx + IDX_W'(r_size)]);

    assign w_add       = (r_state == SWEEP) && !r_mask[w_idx]
                      && (r_color[w_idx] == r_target) && w_nbr;
    assign w_begin_acc = (r_state == IDLE) && BEGIN_GAME;

    always_ff @(posedge MASTER_CLOCK or posedge RESET) begin
        if (RESET) begin
            r_state      <= IDLE;
            r_size       <= ROW_W'(MAX_SIZE);
            r_knum       <= '0;
            r_nn         <= IDX_W'(CELLS);
            r_color      <= '0;
            r_mask       <= '0;
            r_target     <= '0;
            r_changed    <= 1'b0;
            r_begin_mode <= 1'b0;
            r_skip       <= 1'b0;
            r_ack        <= 1'b0;
            r_busy       <= 1'b0;
            r_init       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (LOAD_WE && (LOAD_ADDR < r_nn))
                        r_color[LOAD_ADDR] <= LOAD_COLOR;
                    if (w_begin_acc) begin
                        r_size       <= final_SIZE;
                        r_knum       <= final_COLOR_NUM;
                        r_nn         <= IDX_W'(final_SIZE) * IDX_W'(final_SIZE);
                        r_mask       <= CELLS'(1);
                        r_target     <= r_color[0];
                        r_begin_mode <= 1'b1;
                        r_changed    <= 1'b0;
                        r_state      <= SWEEP;
                    end else if (COLOR_SEL_SIG && !r_busy) begin
                        r_target     <= COLOR_SELECTED;
                        r_busy       <= 1'b1;
                        r_begin_mode <= 1'b0;
                        r_changed    <= 1'b0;
                        // Illegal colour: two busy cycles in SWEEP_END, no sweep.
                        if (K_W'(COLOR_SELECTED) >= r_knum) begin
                            r_skip  <= 1'b1;
                            r_state <= SWEEP_END;
                        end else begin
                            r_state <= SWEEP;
                        end
                    end
                end
                SWEEP: begin
                    if (r_mask[w_idx]) begin
                        r_color[w_idx] <= r_target;
                    end else if (w_add) begin
                        r_mask[w_idx] <= 1'b1;
                        r_changed     <= 1'b1;
                    end
                    if (w_last)
                        r_state <= SWEEP_END;
                end
                SWEEP_END: begin
                    if (r_skip) begin
                        r_skip <= 1'b0;
                    end else if (r_changed) begin
                        r_changed <= 1'b0;
                        r_state   <= SWEEP;
                    end else if (r_begin_mode) begin
                        r_ack   <= 1'b1;
                        r_state <= ACK_WAIT;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                ACK_WAIT: begin
                    if (!BEGIN_GAME) begin
                        r_ack        <= 1'b0;
                        r_init       <= 1'b1;
                        r_begin_mode <= 1'b0;
                        r_state      <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Display read port; cells outside the active board read as 0.
    always_ff @(posedge MASTER_CLOCK or posedge RESET) begin
        if (RESET)
            r_rd_color <= '0;
        else
            r_rd_color <= (RD_ADDR < r_nn) ? r_color[RD_ADDR] : '0;
    end

`ifdef WIN_DETECT_EN
    logic [IDX_W-1:0] r_count;
    logic             r_won;

    always_ff @(posedge MASTER_CLOCK or posedge RESET) begin
        if (RESET) begin
            r_count <= '0;
            r_won   <= 1'b0;
        end else begin
            if (w_begin_acc)
                r_count <= IDX_W'(1);
            else if (w_add && (r_count != r_nn))
                r_count <= r_count + IDX_W'(1);
            r_won <= (r_count == r_nn);
        end
    end

    assign FLOOD_COUNT = r_count;
    assign WON         = r_won;
`else
    assign FLOOD_COUNT = '0;
    assign WON         = 1'b0;
`endif

    assign ACK_BEGIN_GAME           = r_ack;
    assign CURRENTLY_CHANGING_COLOR = r_busy;
    assign INITIALIZED              = r_init;
    assign RD_COLOR                 = r_rd_color;
endmodule
